// File: rtl/memh_pkg.sv
// Shared types and helpers for the LSTM hidden-state memory writer.
// Provides address/timestep widths, the FSM state enum and the slot base-address helper.
package memh_pkg;

    localparam int ADDR_W = 9;
    localparam int T_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2,
        CLEAR = 2'd3
    } state_e;

    // First word of slot t when each slot holds num_lstm words.
    function automatic logic [ADDR_W-1:0] slot_base(input logic [T_W-1:0] t,
                                                    input int unsigned    num_lstm);
        int unsigned prod;
        prod = 32'(t) * num_lstm;
        return prod[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/memory_h_writer_h_piso.sv
// Parallel-in serial-out register for one hidden vector.
// Element 0 is presented first; every shift moves the next element to the head and fills with zeros.
module h_piso #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 53
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   shift,
    input  logic [DEPTH*WIDTH-1:0] din,
    output logic [WIDTH-1:0]       dout
);

    logic [DEPTH*WIDTH-1:0] sr_q;
    logic [DEPTH*WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = din;
        end else if (shift) begin
            sr_d = sr_q >> WIDTH;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout = sr_q[WIDTH-1:0];

endmodule

// File: rtl/memory_h_writer.sv
// Serialises one hidden vector per timestep into word writes and tracks the timestep/read slot.
// Optional macro MEMH_ZERO_INIT_EN: seq_start first clears slot 0 (h0) to zero via a CLEAR state.
module memory_h_writer
    import memh_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_LSTM = 53,
    parameter int TIMESTEP = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      seq_start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_LSTM*WIDTH-1:0] in_h,
    output logic                      wr,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic signed [WIDTH-1:0]   wr_data,
    output logic [ADDR_W-1:0]         rd_addr,
    output logic [T_W-1:0]            t_idx,
    output logic                      busy,
    output logic                      seq_done
);

    if (NUM_LSTM * (TIMESTEP + 1) > 512 || TIMESTEP > 15 || NUM_LSTM < 1 || TIMESTEP < 1) begin : g_cfg_check
        $error("memory_h_writer: illegal NUM_LSTM/TIMESTEP configuration");
    end

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LSTM - 1);
    localparam logic [T_W-1:0]    T_LAST   = T_W'(TIMESTEP);
`ifdef MEMH_ZERO_INIT_EN
    localparam state_e START_STATE = CLEAR;
`else
    localparam state_e START_STATE = IDLE;
`endif

    state_e                    state_q, state_d;
    logic [T_W-1:0]            t_idx_q, t_idx_d;
    logic [ADDR_W-1:0]         rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]         wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]         cnt_q, cnt_d;
    logic                      wr_q, wr_d;
    logic                      piso_load, piso_shift;
    logic [NUM_LSTM*WIDTH-1:0] piso_data;
    logic [WIDTH-1:0]          piso_dout;
    logic                      in_burst, last, restart, accept;

    assign in_burst = (state_q == WRITE) || (state_q == CLEAR);
    assign last     = (cnt_q == LAST_IDX);
    assign restart  = seq_start && ((state_q == IDLE) || (state_q == DONE));
    assign accept   = in_valid && !seq_start && (state_q == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (restart) begin
                    state_d = START_STATE;
                end else if (accept) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (last) begin
                    state_d = (t_idx_q == T_LAST) ? DONE : IDLE;
                end
            end
            DONE: begin
                if (restart) begin
                    state_d = START_STATE;
                end
            end
            CLEAR: begin
                if (last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        seq_done = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            WRITE:   busy     = 1'b1;
            CLEAR:   busy     = 1'b1;
            DONE:    seq_done = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    // Write strobe and address lead the piso head by nothing: all three change on the same edge.
    always_comb begin
        t_idx_d    = t_idx_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        piso_load  = 1'b0;
        piso_shift = 1'b0;
        piso_data  = in_h;

        if (accept) begin
            wr_d      = 1'b1;
            wr_addr_d = slot_base(t_idx_q, NUM_LSTM);
            cnt_d     = '0;
            piso_load = 1'b1;
        end

        if (restart) begin
            t_idx_d   = T_W'(1);
            rd_addr_d = '0;
`ifdef MEMH_ZERO_INIT_EN
            wr_d      = 1'b1;
            wr_addr_d = '0;
            cnt_d     = '0;
            piso_load = 1'b1;
            piso_data = '0;
`endif
        end

        if (in_burst) begin
            piso_shift = 1'b1;
            if (last) begin
                wr_d = 1'b0;
                if (state_q == WRITE) begin
                    rd_addr_d = slot_base(t_idx_q, NUM_LSTM);
                    if (t_idx_q != T_LAST) begin
                        t_idx_d = t_idx_q + T_W'(1);
                    end
                end
            end else begin
                cnt_d     = cnt_q + ADDR_W'(1);
                wr_addr_d = wr_addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_idx_q   <= T_W'(1);
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
        end else begin
            t_idx_q   <= t_idx_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
        end
    end

    h_piso #(
        .WIDTH(WIDTH),
        .DEPTH(NUM_LSTM)
    ) u_piso (
        .clk  (clk),
        .rst  (rst),
        .load (piso_load),
        .shift(piso_shift),
        .din  (piso_data),
        .dout (piso_dout)
    );

    assign wr      = wr_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = piso_dout;
    assign rd_addr = rd_addr_q;
    assign t_idx   = t_idx_q;

endmodule
